// File: rtl/bet_bank_ctrl.sv
// Blackjack bankroll and wager controller: button-driven bet entry, lock/deduct on deal, settlement.
// Optional double-down support is compiled in when BJ_DOUBLE_DOWN_EN is defined.
module bet_bank_ctrl #(
  parameter int BANK_W     = 10,
  parameter int BET_W      = 8,
  parameter int START_BANK = 200,
  parameter int MAX_BET    = 99
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_1,
  input  logic              inc_5,
  input  logic              inc_10,
  input  logic              inc_25,
  input  logic              clear_bet,
  input  logic              place,
  input  logic              double,
  input  logic              outcome_valid,
  input  logic [1:0]        outcome,
  output logic [BANK_W-1:0] bank,
  output logic [BET_W-1:0]  bet,
  output logic              bet_locked,
  output logic              broke,
  output logic              settle_done,
  output logic [1:0]        state_dbg
);

  // Handshake: place, double and outcome_valid are single-cycle strobes with no ready;
  // each is acted on only in the state that accepts it and is silently dropped elsewhere.

  localparam int AW = BANK_W + 2;
  localparam logic [AW-1:0] MAX_X    = AW'(MAX_BET);
  localparam logic [AW-1:0] BANK_SAT = AW'({BANK_W{1'b1}});

  typedef enum logic [1:0] {
    BETTING = 2'd0,
    LOCKED  = 2'd1,
    BROKE   = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [BANK_W-1:0] bank_nx;
  logic [BET_W-1:0]  bet_nx;
  logic              settle_nx;
  logic [3:0]        prev_q;
  logic [3:0]        inc_now;
  logic [3:0]        edges;
  logic              do_double;
  logic [AW-1:0]     bank_x, bet_x, inc_sum, cand, limit, credit, credited;

`ifdef BJ_DOUBLE_DOWN_EN
  logic dd_used, dd_used_nx;
`else
  logic unused_double;
  assign unused_double = double;
`endif

  assign inc_now = {inc_25, inc_10, inc_5, inc_1};
  assign edges   = inc_now & ~prev_q;

  always_comb begin
    bank_x   = AW'(bank);
    bet_x    = AW'(bet);
    inc_sum  = (edges[0] ? AW'(1)  : '0) + (edges[1] ? AW'(5)  : '0)
             + (edges[2] ? AW'(10) : '0) + (edges[3] ? AW'(25) : '0);
    limit    = (bank_x < MAX_X) ? bank_x : MAX_X;
    cand     = bet_x + inc_sum;
    unique case (outcome)
      2'b00:   credit = '0;
      2'b01:   credit = bet_x;
      2'b10:   credit = bet_x + bet_x;
      default: credit = bet_x + bet_x + (bet_x >> 1);
    endcase
    credited = bank_x + credit;
    if (credited > BANK_SAT) credited = BANK_SAT;
  end

  always_comb begin
`ifdef BJ_DOUBLE_DOWN_EN
    do_double  = double && !dd_used && (bank_x >= bet_x);
    dd_used_nx = dd_used;
`else
    do_double  = 1'b0;
`endif
    state_nx  = state;
    bank_nx   = bank;
    bet_nx    = bet;
    settle_nx = 1'b0;
    unique case (state)
      BETTING: begin
        if (place && (bet != '0)) begin
          bank_nx  = BANK_W'(bank_x - bet_x);
          state_nx = LOCKED;
        end else if (clear_bet) begin
          bet_nx = '0;
        end else begin
          bet_nx = BET_W'((cand < limit) ? cand : limit);
        end
      end
      LOCKED: begin
        // A double in the same cycle as an outcome wins; settlement waits for the next outcome.
        if (do_double) begin
          bank_nx = BANK_W'(bank_x - bet_x);
          bet_nx  = BET_W'(bet_x << 1);
`ifdef BJ_DOUBLE_DOWN_EN
          dd_used_nx = 1'b1;
`endif
        end else if (outcome_valid) begin
          bank_nx   = BANK_W'(credited);
          bet_nx    = '0;
          settle_nx = 1'b1;
          state_nx  = (credited == '0) ? BROKE : BETTING;
`ifdef BJ_DOUBLE_DOWN_EN
          dd_used_nx = 1'b0;
`endif
        end
      end
      BROKE: begin
        bank_nx = '0;
        bet_nx  = '0;
      end
      default: begin
        state_nx = BETTING;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BETTING;
      bank        <= BANK_W'(START_BANK);
      bet         <= '0;
      settle_done <= 1'b0;
      prev_q      <= '0;
`ifdef BJ_DOUBLE_DOWN_EN
      dd_used     <= 1'b0;
`endif
    end else begin
      state       <= state_nx;
      bank        <= bank_nx;
      bet         <= bet_nx;
      settle_done <= settle_nx;
      prev_q      <= inc_now;
`ifdef BJ_DOUBLE_DOWN_EN
      dd_used     <= dd_used_nx;
`endif
    end
  end

  assign bet_locked = (state == LOCKED);
  assign broke      = (state == BROKE);
  assign state_dbg  = state;

endmodule

// File: tb/tb_bet_bank_ctrl.sv
// Bench for bet_bank_ctrl: directed scenarios plus random traffic against an arithmetic bankroll model.
// Double-down scenarios are included when BJ_DOUBLE_DOWN_EN is defined.
module tb_bet_bank_ctrl;

  localparam int BANK_W     = 10;
  localparam int BET_W      = 8;
  localparam int START_BANK = 200;
  localparam int MAX_BET    = 99;
  localparam int BANK_MAX   = (1 << BANK_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              inc_1 = 1'b0, inc_5 = 1'b0, inc_10 = 1'b0, inc_25 = 1'b0;
  logic              clear_bet = 1'b0, place = 1'b0, dbl = 1'b0;
  logic              outcome_valid = 1'b0;
  logic [1:0]        outcome = 2'b00;
  logic [BANK_W-1:0] bank;
  logic [BET_W-1:0]  bet;
  logic              bet_locked, broke, settle_done;
  logic [1:0]        state_dbg;

  int checks = 0;
  int errors = 0;

  // Reference model: plain integers and flags describing the table.
  int   m_bank, m_bet;
  bit   m_locked, m_broke, m_doubled, m_settle;
  bit [3:0] m_prev;

  bet_bank_ctrl #(
    .BANK_W(BANK_W), .BET_W(BET_W), .START_BANK(START_BANK), .MAX_BET(MAX_BET)
  ) dut (
    .clk(clk), .rst(rst),
    .inc_1(inc_1), .inc_5(inc_5), .inc_10(inc_10), .inc_25(inc_25),
    .clear_bet(clear_bet), .place(place), .double(dbl),
    .outcome_valid(outcome_valid), .outcome(outcome),
    .bank(bank), .bet(bet), .bet_locked(bet_locked), .broke(broke),
    .settle_done(settle_done), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("bank", 32'(bank), m_bank);
    check("bet", 32'(bet), m_bet);
    check("bet_locked", 32'(bet_locked), 32'(m_locked));
    check("broke", 32'(broke), 32'(m_broke));
    check("settle_done", 32'(settle_done), 32'(m_settle));
  endtask

  task automatic model_step(input bit r, input bit [3:0] inc, input bit clr, input bit plc,
                            input bit dd, input bit ov, input bit [1:0] oc);
    bit [3:0] e;
    int sum, lim, credit;
    m_settle = 1'b0;
    if (r) begin
      m_bank = START_BANK; m_bet = 0; m_locked = 0; m_broke = 0; m_doubled = 0; m_prev = '0;
      return;
    end
    e      = inc & ~m_prev;
    m_prev = inc;
    sum    = (e[0] ? 1 : 0) + (e[1] ? 5 : 0) + (e[2] ? 10 : 0) + (e[3] ? 25 : 0);
    if (m_broke) begin
      m_bank = 0; m_bet = 0;
    end else if (!m_locked) begin
      if (plc && m_bet != 0) begin
        m_bank   = m_bank - m_bet;
        m_locked = 1;
      end else if (clr) begin
        m_bet = 0;
      end else begin
        lim   = (m_bank < MAX_BET) ? m_bank : MAX_BET;
        m_bet = (m_bet + sum < lim) ? m_bet + sum : lim;
      end
    end else begin
`ifdef BJ_DOUBLE_DOWN_EN
      if (dd && !m_doubled && m_bank >= m_bet) begin
        m_bank    = m_bank - m_bet;
        m_bet     = 2 * m_bet;
        m_doubled = 1;
        return;
      end
`endif
      if (ov) begin
        case (oc)
          2'd0:    credit = 0;
          2'd1:    credit = m_bet;
          2'd2:    credit = 2 * m_bet;
          default: credit = 2 * m_bet + m_bet / 2;
        endcase
        m_bank    = (m_bank + credit > BANK_MAX) ? BANK_MAX : m_bank + credit;
        m_bet     = 0;
        m_locked  = 0;
        m_doubled = 0;
        m_settle  = 1;
        if (m_bank == 0) m_broke = 1;
      end
    end
  endtask

  task automatic cycle(input bit [3:0] inc, input bit clr = 0, input bit plc = 0, input bit dd = 0,
                       input bit ov = 0, input bit [1:0] oc = 2'd0, input bit r = 0);
    {inc_25, inc_10, inc_5, inc_1} = inc;
    clear_bet = clr; place = plc; dbl = dd; outcome_valid = ov; outcome = oc; rst = r;
    @(posedge clk);
    model_step(r, inc, clr, plc, dd, ov, oc);
    #1;
    check_all();
  endtask

  // idx: 0=inc_1, 1=inc_5, 2=inc_10, 3=inc_25
  task automatic press(input int idx);
    cycle(4'(1 << idx));
    cycle(4'd0);
  endtask

  initial begin
    cycle(4'd0, 0, 0, 0, 0, 2'd0, 1);
    check("reset_bank", 32'(bank), START_BANK);
    check("reset_bet", 32'(bet), 0);

    // Four 25s then a 10 clamp at the table limit.
    repeat (4) press(3);
    press(2);
    check("clamp_bet", 32'(bet), 99);
    check("clamp_bank", 32'(bank), 200);

    // Holding a button counts once.
    cycle(4'd0, 1);
    repeat (10) cycle(4'b1000);
    cycle(4'd0);
    check("hold_bet", 32'(bet), 25);

    // Simultaneous edges add up.
    cycle(4'd0, 1);
    cycle(4'b0011);
    check("simul_bet", 32'(bet), 6);
    cycle(4'd0);

    // Blackjack pays 3:2.
    cycle(4'd0, 0, 0, 0, 0, 2'd0, 1);
    press(3); press(2); press(1);
    check("bj_bet", 32'(bet), 40);
    cycle(4'd0, 0, 1, 0, 1, 2'd3);
    check("bj_place_bank", 32'(bank), 160);
    check("bj_locked", 32'(bet_locked), 1);
    cycle(4'd0, 0, 0, 0, 1, 2'd3);
    check("bj_bank", 32'(bank), 260);
    check("bj_settle", 32'(settle_done), 1);
    cycle(4'd0);
    check("bj_settle_drop", 32'(settle_done), 0);

    // Drain the bank to 30, bet clamps to bank, lose goes broke.
    cycle(4'd0, 0, 0, 0, 0, 2'd0, 1);
    repeat (4) press(3);
    cycle(4'd0, 0, 1);
    cycle(4'd0, 0, 0, 0, 1, 2'd0);
    press(3); press(3); press(2); press(2); press(0);
    cycle(4'd0, 0, 1);
    cycle(4'd0, 0, 0, 0, 1, 2'd0);
    check("drain_bank", 32'(bank), 30);
    press(3); press(3);
    check("bank_clamp_bet", 32'(bet), 30);
    cycle(4'd0, 0, 1);
    cycle(4'd0, 0, 0, 0, 1, 2'd0);
    check("broke_flag", 32'(broke), 1);
    check("broke_bank", 32'(bank), 0);
    press(3);
    cycle(4'd0, 0, 1, 1, 1, 2'd2);
    check("broke_sticky", 32'(broke), 1);

    // Reset mid-hand forfeits the wager.
    cycle(4'd0, 0, 0, 0, 0, 2'd0, 1);
    press(2); press(2);
    cycle(4'd0, 0, 1);
    check("mid_locked", 32'(bet_locked), 1);
    cycle(4'd0, 0, 0, 0, 0, 2'd0, 1);
    check("mid_rst_bank", 32'(bank), 200);
    check("mid_rst_locked", 32'(bet_locked), 0);

`ifdef BJ_DOUBLE_DOWN_EN
    press(3); press(3);
    cycle(4'd0, 0, 1);
    cycle(4'd0, 0, 0, 1);
    check("dd_bank", 32'(bank), 100);
    check("dd_bet", 32'(bet), 100);
    cycle(4'd0, 0, 0, 1);
    check("dd_second", 32'(bet), 100);
    cycle(4'd0, 0, 0, 0, 1, 2'd2);
    check("dd_win_bank", 32'(bank), 300);
`else
    press(3); press(3);
    cycle(4'd0, 0, 1);
    cycle(4'd0, 0, 0, 1);
    check("nodd_bet", 32'(bet), 50);
    cycle(4'd0, 0, 0, 0, 1, 2'd2);
    check("nodd_win_bank", 32'(bank), 250);
`endif

    // Random traffic.
    cycle(4'd0, 0, 0, 0, 0, 2'd0, 1);
    for (int i = 0; i < 1500; i++) begin
      cycle(4'($urandom_range(0, 15)),
            ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 3) == 0),
            2'($urandom_range(0, 3)),
            ($urandom_range(0, 119) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bet_bank_ctrl.md
# bet_bank_ctrl

Clocked bankroll and wager controller for the blackjack table. It holds the player's bank and current bet in registers and turns synchronized button presses into single-step bet increments, clamped to a table limit and to the available bank. It locks and deducts the wager when a hand is dealt and settles win, push, lose or blackjack (3:2) back into the bank. It sits between the button/synchronizer front end and the game FSM, and drives the existing decimal display blocks.

## Interface
- BANK_W, 10: bank register width. The bank saturates at 2^BANK_W−1.
- BET_W, 8: bet register width. Must hold 2×MAX_BET.
- START_BANK, 200: bank value loaded on reset.
- MAX_BET, 99: table limit on the wager accumulated from the increment buttons.

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- inc_1, inc_5, inc_10, inc_25  in  1 each  synchronized button levels; each rising edge adds 1, 5, 10 or 25 to the bet
- clear_bet  in  1  level; zeroes the bet while in BETTING
- place  in  1  pulse; locks the bet and deducts it from the bank
- double  in  1  pulse; doubles the locked bet (only with BJ_DOUBLE_DOWN_EN)
- outcome_valid  in  1  pulse; settle the locked hand
- outcome  in  2  00 lose, 01 push, 10 win, 11 blackjack
- bank  out  BANK_W  current bank, registered
- bet  out  BET_W  current bet, registered
- bet_locked  out  1  high in LOCKED
- broke  out  1  high in BROKE
- settle_done  out  1  one-cycle pulse after settlement

## Operation
- States: BETTING, LOCKED, BROKE.
- Edge detection: one previous-value register per inc_* input. An edge is current=1 and previous=0. Holding a button gives exactly one increment.
- BETTING:
  - The sum of all edges seen this cycle is added to bet (simultaneous presses add up).
  - The result is clamped to min(MAX_BET, bank).
  - If clear_bet is high, bet becomes 0 and any increments that cycle are dropped.
- BETTING, place=1 and bet≠0: bank ← bank−bet, go to LOCKED. Any increments or clear that cycle are dropped.
- BETTING, place=1 and bet=0: ignored.
- LOCKED: inc_*, clear_bet and place are ignored, but the edge registers keep tracking.
- LOCKED, outcome_valid=1: bank is credited as follows, then bet ← 0 and settle_done pulses.
  - lose: +0
  - push: +bet
  - win: +2×bet
  - blackjack: +bet + bet + floor(bet/2)
- Arithmetic is done at BANK_W+2 bits. The credited bank saturates at 2^BANK_W−1.
- After settling: go to BROKE if the new bank is 0, otherwise go to BETTING.
- outcome_valid in BETTING or BROKE is ignored.
- BROKE: all inputs are ignored, bank=0, bet=0. Only rst exits this state.
- Reset (at any time, including mid-hand) gives bank=START_BANK, bet=0, state BETTING, settle_done=0, edge registers=0. A locked wager is forfeited.

## Timing
- All outputs are registered. An event sampled at rising edge N is visible after edge N.
- Increment latency: 1 cycle from the first high sample to the bet update.
- place → bet_locked=1 and the deducted bank appear on the same following cycle.
- outcome_valid → the credited bank, bet=0, bet_locked=0 and settle_done=1 appear together one cycle later. settle_done is high for exactly 1 cycle.
- place and outcome_valid in the same cycle in BETTING: place is taken and outcome is ignored.

## Configuration
- BJ_DOUBLE_DOWN_EN defined:
  - In LOCKED, a double pulse with bank ≥ bet does bank ← bank−bet and bet ← 2×bet.
  - At most one double is allowed per hand, tracked by an internal flag that is cleared on settle or reset.
  - double with bank < bet, or a second double, is ignored.
  - double and outcome_valid in the same cycle: the double is applied first, and settlement happens on the next valid outcome.
- BJ_DOUBLE_DOWN_EN undefined: the double input is unused and has no logic. bet never exceeds MAX_BET.

## Test plan
- Reset, then press inc_25 four times, then inc_10 once → bet=99 (clamped), bank=200. Holding inc_25 high for 10 cycles adds only 25.
- Simultaneous inc_1 and inc_5 edges from bet=0 → bet=6 after one cycle.
- bet=40, place, outcome=11 → after place bank=160; after settlement bank=260, bet=0, settle_done high for 1 cycle.
- bank=30, press inc_25 twice → bet=30. place, outcome=00 → bank=0, broke=1. Further presses and outcomes have no effect until rst.
- bet=20, place, assert rst while LOCKED → bank=200, bet=0, bet_locked=0 on the next cycle.
- Double-down (macro defined): bet=50, place, double → bank=100, bet=100. A second double is ignored. outcome=10 → bank=300.
